int_to_fp_converter: RTL

//  Multi-cycle 32-bit integer -> IEEE-754 single-precision converter (cvt.s.w path of the FPU).

---
 rtl/fp_pkg.sv | 14 +
 rtl/fp_round_ne.sv | 20 ++
 rtl/int_to_fp_converter.sv | 102 ++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// fp_pkg: shared single-precision field widths, bias, converter FSM states and packed float type.
package fp_pkg;
    localparam int FP_EXP_W    = 8;
    localparam int FP_MANT_W   = 23;
    localparam int FP_EXP_BIAS = 127;

    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_e;

    typedef struct packed {
        logic                 sign;
        logic [FP_EXP_W-1:0]  exp;
        logic [FP_MANT_W-1:0] mant;
    } fp_single_t;
endpackage

// File: rtl/fp_round_ne.sv
// fp_round_ne: rounds a normalised 32-bit magnitude to a 23-bit mantissa, nearest-even, with carry into exp.
module fp_round_ne
    import fp_pkg::*;
(
    input  logic [31:0]          mag_i,
    input  logic [FP_EXP_W-1:0]  exp_i,
    output logic [FP_EXP_W-1:0]  exp_o,
    output logic [FP_MANT_W-1:0] mant_o,
    output logic                 inexact_o
);
    logic                 up;
    logic [FP_MANT_W:0]   sum;

    // An unnormalised (zero) magnitude never rounds up.
    assign up        = mag_i[31] & mag_i[7] & ((|mag_i[6:0]) | mag_i[8]);
    assign sum       = {1'b0, mag_i[30:8]} + {{FP_MANT_W{1'b0}}, up};
    assign mant_o    = sum[FP_MANT_W-1:0];
    assign exp_o     = exp_i + {{(FP_EXP_W-1){1'b0}}, sum[FP_MANT_W]};
    assign inexact_o = |mag_i[7:0];
endmodule

// File: rtl/int_to_fp_converter.sv
// int_to_fp_converter: multi-cycle 32-bit integer to IEEE-754 single converter.
// Normalises one bit per cycle, rounds nearest-even, start/done handshake.
module int_to_fp_converter
    import fp_pkg::*;
#(
    parameter bit SIGNED_IN = 1'b1,
    parameter int EXP_BIAS  = FP_EXP_BIAS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] int_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        inexact
);
    state_e                state_q, state_d;
    logic [31:0]           mag_q, mag_d;
    logic [FP_EXP_W-1:0]   exp_q, exp_d;
    logic                  sign_q, sign_d;
    fp_single_t            result_q, result_d;
    logic                  inexact_q, inexact_d;
    logic                  done_q, done_d;
    logic [FP_EXP_W-1:0]   rnd_exp;
    logic [FP_MANT_W-1:0]  rnd_mant;
    logic                  rnd_inexact;

    fp_round_ne u_round (
        .mag_i     (mag_q),
        .exp_i     (exp_q),
        .exp_o     (rnd_exp),
        .mant_o    (rnd_mant),
        .inexact_o (rnd_inexact)
    );

    always_comb begin
        state_d   = state_q;
        mag_d     = mag_q;
        exp_d     = exp_q;
        sign_d    = sign_q;
        result_d  = result_q;
        inexact_d = inexact_q;
        done_d    = state_q == DONE;
        unique case (state_q)
            IDLE: begin
                // The done pulse cycle also refuses new work.
                if (start && !done_q) begin
                    sign_d = SIGNED_IN && int_in[31];
                    mag_d  = sign_d ? -int_in : int_in;
                    exp_d  = FP_EXP_W'(EXP_BIAS + 31);
                    if (int_in == 32'h0) begin
                        result_d  = '0;
                        inexact_d = 1'b0;
                        state_d   = DONE;
                    end else begin
                        state_d = NORM;
                    end
                end
            end
            NORM: begin
                if (mag_q[31]) begin
                    state_d = ROUND;
                end else begin
                    mag_d = mag_q << 1;
                    exp_d = exp_q - 1'b1;
                end
            end
            ROUND: begin
                result_d  = '{sign: sign_q, exp: rnd_exp, mant: rnd_mant};
                inexact_d = rnd_inexact;
                state_d   = DONE;
            end
            DONE: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mag_q     <= '0;
            exp_q     <= '0;
            sign_q    <= 1'b0;
            result_q  <= '0;
            inexact_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mag_q     <= mag_d;
            exp_q     <= exp_d;
            sign_q    <= sign_d;
            result_q  <= result_d;
            inexact_q <= inexact_d;
            done_q    <= done_d;
        end
    end

    assign busy    = state_q != IDLE;
    assign done    = done_q;
    assign result  = result_q;
    assign inexact = inexact_q;
endmodule
